// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   - Default source count and claim ID width.
//   - Register byte offsets.
//   - Dispatch state encoding.
package irq_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int ID_W_DEF    = 3;

    localparam logic [4:0] OFF_PENDING  = 5'h00;
    localparam logic [4:0] OFF_ENABLE   = 5'h04;
    localparam logic [4:0] OFF_TRIGGER  = 5'h08;
    localparam logic [4:0] OFF_CLAIM    = 5'h0C;
    localparam logic [4:0] OFF_COMPLETE = 5'h10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
//   req_i   : request vector
//   valid_o : at least one request bit is set
//   idx_o   : index of the lowest set request bit (0 when none)
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx_o   = req_i[i] ? W'(i) : idx_o;
            valid_o = valid_o | req_i[i];
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes raw interrupt lines, latches them as
// pending (edge or level per source), and dispatches the lowest enabled
// pending source to the CPU via a claim/complete handshake.
//   clk, rst_n          : clock, async active-low reset
//   src_irq             : raw interrupt lines
//   reg_req/we/addr/wdata : single-cycle register access
//   reg_rdata/rvalid    : read response, one cycle after the request
//   cpu_interrupt       : registered interrupt to the CPU
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [4:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rvalid,
    output logic               cpu_interrupt
);

    logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q;
    logic [1:0]         warm_q;
    logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d, trig_q, trig_d;
    logic [NUM_SRC-1:0] edge_s, set_s, clr_s;
    irq_state_e         state_q, state_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, irq_q;
    logic               rd_s, wr_s, claim_ok_s, complete_ok_s, valid_s, armed_s;
    logic [4:0]         off_s;
    logic [ID_W-1:0]    idx_s, winner_s;
    logic               unused_s;

    assign rd_s     = reg_req & ~reg_we;
    assign wr_s     = reg_req & reg_we;
    assign off_s    = {reg_addr[4:2], 2'b00};
    assign unused_s = ^{reg_addr[1:0], reg_wdata[31:NUM_SRC]};

    irq_prio_enc #(.N(NUM_SRC), .W(ID_W)) u_prio (
        .req_i   (pend_q & en_q),
        .valid_o (valid_s),
        .idx_o   (idx_s)
    );

    assign winner_s      = idx_s + {{(ID_W-1){1'b0}}, 1'b1};
    assign claim_ok_s    = rd_s & (off_s == OFF_CLAIM) & (state_q == ASSERT) & valid_s;
    assign complete_ok_s = wr_s & (off_s == OFF_COMPLETE) & (reg_wdata[ID_W-1:0] == claim_id_q);

    // Edges are masked until the synchronizer and history have been refilled
    // after reset, so a line already high at release never looks like an edge.
    assign armed_s = (warm_q == 2'd3);
    assign edge_s  = sync2_q & ~hist_q & {NUM_SRC{armed_s}};
    assign set_s   = (trig_q & edge_s) | (~trig_q & sync2_q);
    assign clr_s   = claim_ok_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << idx_s) : {NUM_SRC{1'b0}};
    assign pend_d  = (pend_q & ~clr_s) | set_s;

    // Input synchronizer, edge history and post-reset settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {NUM_SRC{1'b0}};
            sync2_q <= {NUM_SRC{1'b0}};
            hist_q  <= {NUM_SRC{1'b0}};
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= src_irq;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            warm_q  <= armed_s ? 2'd3 : warm_q + 2'd1;
        end
    end

    // ENABLE / TRIGGER write decode.
    always_comb begin
        en_d   = en_q;
        trig_d = trig_q;
        if (wr_s) begin
            case (off_s)
                OFF_ENABLE:  en_d   = reg_wdata[NUM_SRC-1:0];
                OFF_TRIGGER: trig_d = reg_wdata[NUM_SRC-1:0];
                default: begin
                    en_d   = en_q;
                    trig_d = trig_q;
                end
            endcase
        end else begin
            en_d = en_q;
        end
    end

    // Read data mux; unmapped and write-only offsets read as zero.
    always_comb begin
        rdata_d = 32'h0;
        if (rd_s) begin
            case (off_s)
                OFF_PENDING: rdata_d = 32'(pend_q);
                OFF_ENABLE:  rdata_d = 32'(en_q);
                OFF_TRIGGER: rdata_d = 32'(trig_q);
                OFF_CLAIM:   rdata_d = claim_ok_s ? 32'(winner_s) : 32'h0;
                default:     rdata_d = 32'h0;
            endcase
        end else begin
            rdata_d = 32'h0;
        end
    end

    // Dispatch FSM next state and claimed ID.
    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        case (state_q)
            IDLE: begin
                if (valid_s) begin
                    state_d = ASSERT;
                end else begin
                    state_d = IDLE;
                end
            end
            ASSERT: begin
                if (claim_ok_s) begin
                    state_d    = SERVICE;
                    claim_id_d = winner_s;
                end else if (!valid_s) begin
                    // ENABLE withdrawn before the claim: nothing left to serve.
                    state_d = IDLE;
                end else begin
                    state_d = ASSERT;
                end
            end
            SERVICE: begin
                if (complete_ok_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Architectural state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= {NUM_SRC{1'b0}};
            en_q       <= {NUM_SRC{1'b0}};
            trig_q     <= {NUM_SRC{1'b0}};
            state_q    <= IDLE;
            claim_id_q <= {ID_W{1'b0}};
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            en_q       <= en_d;
            trig_q     <= trig_d;
            state_q    <= state_d;
            claim_id_q <= claim_id_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rd_s;
            irq_q      <= (state_q == ASSERT);
        end
    end

    assign reg_rdata     = rdata_q;
    assign reg_rvalid    = rvalid_q;
    assign cpu_interrupt = irq_q;

endmodule
